// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, req/ack instruction fetch, issue to the ControlUnit, and next-PC resolution.
// Optional MIPS branch delay slot: define IFU_DELAY_SLOT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        Branch,
    input  logic        nBranch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [5:0]  OP,
    output logic [5:0]  func,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fault
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_ISSUE, S_FAULT} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   pc_r;
    logic [31:0]   instr_r;
    logic [31:0]   jump_tgt;
    logic [31:0]   branch_tgt;
    logic [31:0]   redirect_tgt;
    logic          redirect;

`ifdef IFU_DELAY_SLOT_EN
    logic          pend_valid;
    logic [31:0]   pend_tgt;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = imem_ack ? S_ISSUE : S_WAIT;
            S_WAIT: begin
                if (imem_ack)                     state_nxt = S_ISSUE;
                else if (cnt == CW'(TIMEOUT_CYC)) state_nxt = S_FAULT;
            end
            S_ISSUE: if (!stall) state_nxt = S_FETCH;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Outputs are gated by rst_n so they read inactive throughout a reset, not only after its edge.
    always_comb begin
        imem_req    = rst_n && (state == S_FETCH || state == S_WAIT);
        instr_valid = rst_n && (state == S_ISSUE);
        fault       = rst_n && (state == S_FAULT);
    end

    assign pc_plus4     = pc_r + 32'd4;
    assign jump_tgt     = {pc_plus4[31:28], instr_r[25:0], 2'b00};
    assign branch_tgt   = pc_plus4 + {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    assign redirect     = Jump | (Branch & Zero) | (nBranch & ~Zero);
    assign redirect_tgt = Jump ? jump_tgt : branch_tgt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC;
            instr_r <= '0;
            cnt     <= '0;
`ifdef IFU_DELAY_SLOT_EN
            pend_valid <= 1'b0;
            pend_tgt   <= '0;
`endif
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) instr_r <= imem_rdata;
                    else          cnt     <= CW'(1);
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        instr_r <= imem_rdata;
                        cnt     <= '0;
                    end else if (cnt != CW'(TIMEOUT_CYC)) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
`ifdef IFU_DELAY_SLOT_EN
                        // Issuing the delay slot itself: its control inputs are ignored.
                        if (pend_valid) begin
                            pc_r       <= pend_tgt;
                            pend_valid <= 1'b0;
                        end else begin
                            pc_r <= pc_plus4;
                            if (redirect) begin
                                pend_valid <= 1'b1;
                                pend_tgt   <= redirect_tgt;
                            end
                        end
`else
                        pc_r <= redirect ? redirect_tgt : pc_plus4;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign instr     = instr_r;
    assign OP        = instr_r[31:26];
    assign func      = instr_r[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: scoreboarded fetch/issue, branch/jump redirects, stall, wrap and timeout.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        Branch, nBranch, Jump, Zero;
    logic [31:0] instr;
    logic        instr_valid;
    logic [5:0]  OP, func;
    logic [31:0] pc, pc_plus4;
    logic        fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .Branch(Branch), .nBranch(nBranch), .Jump(Jump), .Zero(Zero),
        .instr(instr), .instr_valid(instr_valid), .OP(OP), .func(func),
        .pc(pc), .pc_plus4(pc_plus4), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serve one fetch at addr after dly wait cycles, then compare the issued instruction against the scoreboard.
    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] word, input int dly);
        exp_t e;
        int   n;
        chk("fetch_req", 32'(imem_req), 32'd1);
        chk("fetch_addr", imem_addr, addr);
        chk("fetch_valid_low", 32'(instr_valid), 32'd0);
        for (int i = 0; i < dly; i++) begin
            tick();
            chk("wait_req", 32'(imem_req), 32'd1);
            chk("wait_addr", imem_addr, addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        sb.push_back('{pc: addr, instr: word});
        tick();
        imem_ack   = 1'b0;
        imem_rdata = '0;
        n = 0;
        while (!instr_valid && n < 4) begin
            tick();
            n++;
        end
        chk("issue_seen", 32'(instr_valid), 32'd1);
        chk("issue_req_low", 32'(imem_req), 32'd0);
        e = sb.pop_front();
        chk("instr", instr, e.instr);
        chk("pc", pc, e.pc);
        chk("op", 32'(OP), 32'(e.instr[31:26]));
        chk("func", 32'(func), 32'(e.instr[5:0]));
        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
    endtask

    task automatic issue(input logic b, input logic nb, input logic j, input logic z);
        Branch = b; nBranch = nb; Jump = j; Zero = z;
        tick();
        Branch = 1'b0; nBranch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0;
        Branch = 1'b0; nBranch = 1'b0; Jump = 1'b0; Zero = 1'b0;

        tick();
        tick();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        imem_ack = 1'b0; imem_rdata = '0;
        rst_n = 1'b1;
        #1;

        // Sequential stream, one with an ack delay
        do_fetch(32'h0000_0000, 32'h0000_0020, 0); issue(0, 0, 0, 0);
        do_fetch(32'h0000_0004, 32'h8C01_0004, 0); issue(0, 0, 0, 0);
        do_fetch(32'h0000_0008, 32'h0022_1825, 0); issue(0, 0, 0, 0);
        do_fetch(32'h0000_000C, 32'h0043_2020, 2); issue(0, 0, 0, 0);

        // beq taken backwards: 0x14 - 16 = 0x04
        do_fetch(32'h0000_0010, 32'h1000_FFFC, 0); issue(1, 0, 0, 1);
`ifdef IFU_DELAY_SLOT_EN
        do_fetch(32'h0000_0014, 32'h0800_0200, 0); issue(0, 0, 1, 0);
`endif
        do_fetch(32'h0000_0004, 32'h0000_0000, 0); issue(0, 0, 0, 0);
        do_fetch(32'h0000_0008, 32'h0000_0000, 0); issue(0, 0, 0, 0);
        do_fetch(32'h0000_000C, 32'h0000_0000, 0); issue(0, 0, 0, 0);

        // bne with Zero=1 not taken, then bne with Zero=0 taken to 0x18 + 8
        do_fetch(32'h0000_0010, 32'h1400_FFFC, 0); issue(0, 1, 0, 1);
        do_fetch(32'h0000_0014, 32'h1400_0002, 0); issue(0, 1, 0, 0);
`ifdef IFU_DELAY_SLOT_EN
        do_fetch(32'h0000_0018, 32'h0000_0000, 0); issue(0, 0, 0, 0);
`endif

        // Jump to 0x400
        do_fetch(32'h0000_0020, 32'h0800_0100, 0); issue(0, 0, 1, 0);
`ifdef IFU_DELAY_SLOT_EN
        do_fetch(32'h0000_0024, 32'h0000_0000, 0); issue(0, 0, 0, 0);
`endif

        // Stall for 3 cycles with a Jump pulse that must be ignored
        do_fetch(32'h0000_0400, 32'h0800_0003, 0);
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            Jump  = (i == 0);
            tick();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_instr", instr, 32'h0800_0003);
            chk("stall_pc", pc, 32'h0000_0400);
        end
        stall = 1'b0; Jump = 1'b0;
        tick();

        // Branch wrapping to 0xFFFF_FFFC, then sequential wrap to 0
        do_fetch(32'h0000_0404, 32'h1000_FEFD, 0); issue(1, 0, 0, 1);
`ifdef IFU_DELAY_SLOT_EN
        do_fetch(32'h0000_0408, 32'h0000_0000, 0); issue(0, 0, 0, 0);
`endif
        do_fetch(32'hFFFF_FFFC, 32'h0000_0000, 0); issue(0, 0, 0, 0);

        // Branch and nBranch both set, Zero=0: nBranch condition redirects to 0x4 + 4
        do_fetch(32'h0000_0000, 32'h1000_0001, 0); issue(1, 1, 0, 0);
`ifdef IFU_DELAY_SLOT_EN
        do_fetch(32'h0000_0004, 32'h0000_0000, 0); issue(0, 0, 0, 0);
`endif
        do_fetch(32'h0000_0008, 32'h0000_0000, 0); issue(0, 0, 0, 0);

        // Timeout: ack withheld at 0xC, fault on the 5th edge after req rose
        chk("to_req0", 32'(imem_req), 32'd1);
        chk("to_addr0", imem_addr, 32'h0000_000C);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("to_fault_low", 32'(fault), 32'd0);
            chk("to_req_held", 32'(imem_req), 32'd1);
        end
        tick();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req_drop", 32'(imem_req), 32'd0);
        chk("to_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        tick();
        chk("late_ack_fault", 32'(fault), 32'd1);
        chk("late_ack_valid", 32'(instr_valid), 32'd0);
        imem_ack = 1'b0;

        rst_n = 1'b0;
        tick();
        chk("clr_fault", 32'(fault), 32'd0);
        chk("clr_req", 32'(imem_req), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("restart_req", 32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr, 32'h0000_0000);
        chk("restart_fault", 32'(fault), 32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
